// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, their response channels and the shared ALU link.
// The arbiter connects through the slave modport; the environment drives the master side.
interface alu_arbiter_if #(
  parameter int W = 16
);
  logic [W-1:0] req0_data_in;
  logic         req0_valid_in;
  logic         req0_cmd_in;
  logic         req0_ready;
  logic [W-1:0] req1_data_in;
  logic         req1_valid_in;
  logic         req1_cmd_in;
  logic         req1_ready;

  logic [W-1:0] rsp0_data_out;
  logic         rsp0_valid_out;
  logic         rsp0_cmd_out;
  logic [W-1:0] rsp1_data_out;
  logic         rsp1_valid_out;
  logic         rsp1_cmd_out;

  logic [W-1:0] alu_data_in;
  logic         alu_valid_in;
  logic         alu_cmd_in;
  logic [W-1:0] alu_data_out;
  logic         alu_valid_out;
  logic         alu_cmd_out;

  modport slave (
    input  req0_data_in, req0_valid_in, req0_cmd_in,
    input  req1_data_in, req1_valid_in, req1_cmd_in,
    input  alu_data_out, alu_valid_out, alu_cmd_out,
    output req0_ready, req1_ready,
    output rsp0_data_out, rsp0_valid_out, rsp0_cmd_out,
    output rsp1_data_out, rsp1_valid_out, rsp1_cmd_out,
    output alu_data_in, alu_valid_in, alu_cmd_in
  );

  modport master (
    output req0_data_in, req0_valid_in, req0_cmd_in,
    output req1_data_in, req1_valid_in, req1_cmd_in,
    output alu_data_out, alu_valid_out, alu_cmd_out,
    input  req0_ready, req1_ready,
    input  rsp0_data_out, rsp0_valid_out, rsp0_cmd_out,
    input  rsp1_data_out, rsp1_valid_out, rsp1_cmd_out,
    input  alu_data_in, alu_valid_in, alu_cmd_in
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin, packet-level arbiter sharing one ALU between two requesters, with
// response routing back to the packet owner and an error response on ALU timeout.
module alu_arbiter #(
  parameter int           W           = 16,
  parameter int           TIMEOUT     = 2000,
  parameter logic [W-1:0] ERR_HEADER  = 16'h0010,
  parameter logic [W-1:0] ERR_PAYLOAD = 16'h0BAD
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FWD, WAIT, RSP, ERR_HDR, ERR_PLD} state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [5:0]    cnt;
  logic [TW-1:0] tmo;

  logic [W-1:0]  alu_data;
  logic          alu_valid;
  logic          alu_cmd;
  logic [W-1:0]  rsp_data;
  logic          rsp_valid;
  logic          rsp_cmd;

  logic          cand0;
  logic          cand1;
  logic          grant0;
  logic          grant1;
  logic          sel;
  logic          sel_valid;
  logic [W-1:0]  sel_data;

  // A tie goes to the requester that was not served last.
  always_comb begin
    cand0     = bus.req0_valid_in & bus.req0_cmd_in;
    cand1     = bus.req1_valid_in & bus.req1_cmd_in;
    grant0    = (state == IDLE) & cand0 & (~cand1 | last);
    grant1    = (state == IDLE) & cand1 & (~cand0 | ~last);
    sel       = (state == IDLE) ? grant1 : owner;
    sel_valid = sel ? bus.req1_valid_in : bus.req0_valid_in;
    sel_data  = sel ? bus.req1_data_in  : bus.req0_data_in;
  end

  assign bus.req0_ready = rst_n & (grant0 | ((state == FWD) & ~owner));
  assign bus.req1_ready = rst_n & (grant1 | ((state == FWD) &  owner));

  assign bus.alu_data_in  = alu_data;
  assign bus.alu_valid_in = alu_valid;
  assign bus.alu_cmd_in   = alu_cmd;

  // One shared response register, steered to the owner's port only.
  assign bus.rsp0_data_out  = owner ? '0 : rsp_data;
  assign bus.rsp0_valid_out = rsp_valid & ~owner;
  assign bus.rsp0_cmd_out   = rsp_cmd & ~owner;
  assign bus.rsp1_data_out  = owner ? rsp_data : '0;
  assign bus.rsp1_valid_out = rsp_valid & owner;
  assign bus.rsp1_cmd_out   = rsp_cmd & owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      tmo       <= '0;
      alu_data  <= '0;
      alu_valid <= 1'b0;
      alu_cmd   <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_cmd   <= 1'b0;
    end else begin
      alu_valid <= 1'b0;
      alu_cmd   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_cmd   <= 1'b0;
      case (state)
        IDLE: begin
          tmo <= '0;
          if (grant0 | grant1) begin
            owner     <= grant1;
            alu_data  <= sel_data;
            alu_valid <= 1'b1;
            alu_cmd   <= 1'b1;
            cnt       <= sel_data[5:0];
            state     <= (sel_data[5:0] == 6'd0) ? WAIT : FWD;
          end
        end
        FWD: begin
          tmo <= '0;
          if (sel_valid) begin
            alu_data  <= sel_data;
            alu_valid <= 1'b1;
            cnt       <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          tmo <= tmo + 1'b1;
          if (bus.alu_valid_out & bus.alu_cmd_out) begin
            rsp_data  <= bus.alu_data_out;
            rsp_valid <= 1'b1;
            rsp_cmd   <= 1'b1;
            state     <= RSP;
          end else if (tmo == TMO_LAST) begin
            state <= ERR_HDR;
          end
        end
        RSP: begin
          rsp_data  <= bus.alu_data_out;
          rsp_valid <= 1'b1;
          last      <= owner;
          state     <= IDLE;
        end
        ERR_HDR: begin
          rsp_data  <= ERR_HEADER;
          rsp_valid <= 1'b1;
          rsp_cmd   <= 1'b1;
          state     <= ERR_PLD;
        end
        ERR_PLD: begin
          rsp_data  <= ERR_PAYLOAD;
          rsp_valid <= 1'b1;
          last      <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a summing ALU model, requester drivers and a
// queue-based scoreboard for forwarded words, grants and responses.
module tb_alu_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) bus ();

  alu_arbiter #(
    .W(W),
    .TIMEOUT(2000),
    .ERR_HEADER(16'h0010),
    .ERR_PAYLOAD(16'h0BAD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [16:0] alu_q[$];
  logic [16:0] rsp0_q[$];
  logic [16:0] rsp1_q[$];
  int          grant_q[$];

  logic pkt_pending = 1'b0;
  logic pend_owner  = 1'b0;
  logic hdr_due     = 1'b0;
  int   alu_delay   = 2;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ALU stand-in: answers header 0 and the sum of the operands after alu_delay cycles.
  logic [5:0]  m_left;
  logic [15:0] m_sum;
  int          m_cd;
  logic [1:0]  m_phase;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_valid_out <= 1'b0;
      bus.alu_cmd_out   <= 1'b0;
      bus.alu_data_out  <= '0;
      m_left  <= '0;
      m_sum   <= '0;
      m_cd    <= 0;
      m_phase <= 2'd0;
    end else begin
      bus.alu_valid_out <= 1'b0;
      bus.alu_cmd_out   <= 1'b0;
      bus.alu_data_out  <= '0;
      if (m_phase == 2'd2) begin
        bus.alu_valid_out <= 1'b1;
        bus.alu_data_out  <= m_sum;
        m_phase <= 2'd0;
      end else if (m_phase == 2'd1) begin
        if (m_cd == 0) begin
          bus.alu_valid_out <= 1'b1;
          bus.alu_cmd_out   <= 1'b1;
          bus.alu_data_out  <= 16'h0000;
          m_phase <= 2'd2;
        end else begin
          m_cd <= m_cd - 1;
        end
      end
      if (bus.alu_valid_in) begin
        if (bus.alu_cmd_in) begin
          m_sum  <= '0;
          m_left <= bus.alu_data_in[5:0];
          if (bus.alu_data_in[5:0] == 6'd0) begin
            m_phase <= 2'd1;
            m_cd    <= alu_delay;
          end
        end else begin
          m_sum  <= m_sum + bus.alu_data_in;
          m_left <= m_left - 6'd1;
          if (m_left == 6'd1) begin
            m_phase <= 2'd1;
            m_cd    <= alu_delay;
          end
        end
      end
    end
  end

  // Scoreboard monitor: acceptances are recorded at the edge, DUT outputs checked 1 ns later.
  logic        a0, a1;
  logic [17:0] exp_alu;
  logic [16:0] exp_rsp;
  int          exp_g;

  always @(posedge clk) begin
    a0 = bus.req0_valid_in & bus.req0_ready;
    a1 = bus.req1_valid_in & bus.req1_ready;
    if (a0 && a1) check_output("single_grant", {a0, a1}, 2'b10);
    if (a0) alu_q.push_back({bus.req0_cmd_in, bus.req0_data_in});
    if (a1) alu_q.push_back({bus.req1_cmd_in, bus.req1_data_in});
    if ((a0 && bus.req0_cmd_in) || (a1 && bus.req1_cmd_in)) begin
      exp_g = (grant_q.size() > 0) ? grant_q.pop_front() : -1;
      check_output("grant_order", (a1 && bus.req1_cmd_in) ? 1 : 0, exp_g);
    end
    #1;
    if (alu_q.size() > 0 || bus.alu_valid_in) begin
      exp_alu = (alu_q.size() > 0) ? {1'b1, alu_q.pop_front()} : 18'h0;
      check_output("alu_fwd", {bus.alu_valid_in, bus.alu_cmd_in, bus.alu_data_in}, exp_alu);
    end
    if (hdr_due) begin
      check_output("rsp_hdr_latency",
                   pend_owner ? (bus.rsp1_valid_out & bus.rsp1_cmd_out)
                              : (bus.rsp0_valid_out & bus.rsp0_cmd_out), 1);
      hdr_due = 1'b0;
    end
    if (bus.alu_valid_out && bus.alu_cmd_out && pkt_pending) begin
      hdr_due     = 1'b1;
      pkt_pending = 1'b0;
    end
    if (bus.rsp0_valid_out) begin
      if (rsp0_q.size() == 0) begin
        check_output("rsp0_stray", bus.rsp0_valid_out, 0);
      end else begin
        exp_rsp = rsp0_q.pop_front();
        check_output("rsp0_word", {bus.rsp0_cmd_out, bus.rsp0_data_out}, exp_rsp);
        if (bus.rsp0_cmd_out && !pend_owner) pkt_pending = 1'b0;
      end
    end
    if (bus.rsp1_valid_out) begin
      if (rsp1_q.size() == 0) begin
        check_output("rsp1_stray", bus.rsp1_valid_out, 0);
      end else begin
        exp_rsp = rsp1_q.pop_front();
        check_output("rsp1_word", {bus.rsp1_cmd_out, bus.rsp1_data_out}, exp_rsp);
        if (bus.rsp1_cmd_out && pend_owner) pkt_pending = 1'b0;
      end
    end
  end

  task automatic drive(input int r, input logic v, input logic [15:0] d, input logic c);
    if (r == 0) begin
      bus.req0_valid_in = v;
      bus.req0_data_in  = d;
      bus.req0_cmd_in   = c;
    end else begin
      bus.req1_valid_in = v;
      bus.req1_data_in  = d;
      bus.req1_cmd_in   = c;
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic push_rsp(input int r, input logic [16:0] w);
    if (r == 0) rsp0_q.push_back(w);
    else        rsp1_q.push_back(w);
  endtask

  // Sends one packet; gap_after >= 0 idles valid for 3 cycles after that word index.
  task automatic apply_stimulus(input int r, input logic [15:0] hdr,
                                input logic [15:0] op0, input logic [15:0] op1,
                                input logic [15:0] op2, input int gap_after,
                                input bit expect_tmo);
    logic [15:0] ops [3];
    logic [15:0] sum;
    logic [15:0] word;
    int          n;
    int          cyc;
    ops = '{op0, op1, op2};
    n   = int'(hdr[5:0]);
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + ops[i];
    if (expect_tmo) begin
      push_rsp(r, {1'b1, 16'h0010});
      push_rsp(r, {1'b0, 16'h0BAD});
    end else begin
      push_rsp(r, {1'b1, 16'h0000});
      push_rsp(r, {1'b0, sum});
    end
    for (int i = 0; i <= n; i++) begin
      if (gap_after >= 0 && i == gap_after + 1) begin
        repeat (3) begin
          @(negedge clk);
          drive(r, 1'b0, 16'h0000, 1'b0);
        end
      end
      word = (i == 0) ? hdr : ops[i-1];
      @(negedge clk);
      drive(r, 1'b1, word, (i == 0));
      cyc = 0;
      #1;
      while (!rdy(r) && cyc < 3000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      if (cyc >= 3000) begin
        check_output("ready_timeout", rdy(r), 1);
        drive(r, 1'b0, 16'h0000, 1'b0);
        return;
      end
      @(posedge clk);
      if (i == n) begin
        pkt_pending = 1'b1;
        pend_owner  = (r != 0);
      end
    end
    @(negedge clk);
    drive(r, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while ((rsp0_q.size() > 0 || rsp1_q.size() > 0) && cyc < 3000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check_output("drain_wait", rsp0_q.size() + rsp1_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.req0_ready, bus.req1_ready,
            bus.rsp0_valid_out, bus.rsp0_cmd_out, bus.rsp1_valid_out, bus.rsp1_cmd_out,
            bus.alu_valid_in, bus.alu_cmd_in,
            bus.rsp0_data_out, bus.rsp1_data_out, bus.alu_data_in};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    drive(1, 1'b0, 16'h0000, 1'b0);
    drive(0, 1'b1, 16'h0101, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_outputs", all_outs(), 64'h0);
    drive(0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] tie round-robin after reset");
    grant_q.push_back(0); grant_q.push_back(1);
    grant_q.push_back(0); grant_q.push_back(1);
    fork
      begin
        apply_stimulus(0, 16'h0101, 16'h0003, 16'h0000, 16'h0000, -1, 1'b0);
        apply_stimulus(0, 16'h0101, 16'h0010, 16'h0000, 16'h0000, -1, 1'b0);
      end
      begin
        apply_stimulus(1, 16'h0101, 16'h0020, 16'h0000, 16'h0000, -1, 1'b0);
        apply_stimulus(1, 16'h0101, 16'h0040, 16'h0000, 16'h0000, -1, 1'b0);
      end
    join
    wait_done();

    $display("[TB] single ADD on req0");
    grant_q.push_back(0);
    apply_stimulus(0, 16'h0002, 16'h000C, 16'h00A0, 16'h0000, -1, 1'b0);
    wait_done();

    $display("[TB] zero-operand header on req1");
    grant_q.push_back(1);
    apply_stimulus(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, -1, 1'b0);
    wait_done();

    $display("[TB] ALU timeout on req0");
    alu_delay = 2050;
    grant_q.push_back(0);
    apply_stimulus(0, 16'h0001, 16'h0005, 16'h0000, 16'h0000, -1, 1'b1);
    n = 0;
    while (rsp0_q.size() > 0 && n < 2100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_output("tmo_window", (n >= 2000 && n <= 2005), 1);
    repeat (80) @(posedge clk);
    alu_delay = 2;
    grant_q.push_back(1);
    apply_stimulus(1, 16'h0001, 16'h0007, 16'h0000, 16'h0000, -1, 1'b0);
    wait_done();

    $display("[TB] payload gap on req0");
    grant_q.push_back(0);
    apply_stimulus(0, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 1, 1'b0);
    wait_done();

    $display("[TB] reset during FWD");
    grant_q.push_back(1);
    @(negedge clk);
    drive(1, 1'b1, 16'h0003, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b1, 16'h0009, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("reset_mid_packet", all_outs(), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    grant_q.push_back(0); grant_q.push_back(1);
    fork
      apply_stimulus(0, 16'h0101, 16'h1111, 16'h0000, 16'h0000, -1, 1'b0);
      apply_stimulus(1, 16'h0101, 16'h2222, 16'h0000, 16'h0000, -1, 1'b0);
    join
    wait_done();

    check_output("alu_q_empty", alu_q.size(), 0);
    check_output("grant_q_empty", grant_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
